// File: rtl/oven_pkg.sv
// Shared oven constants, data widths, recipe slot layout and sequencer states.
package oven_pkg;

   localparam int unsigned INTERVAL = 10;
   localparam int unsigned TEMP_W   = 8;
   localparam int unsigned TIME_W   = 4;

   typedef struct packed {
      logic [TEMP_W-1:0] temp;
      logic [TIME_W-1:0] dur;
   } recipe_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PREHEAT,
      S_COOK,
      S_PAUSED,
      S_NEXT,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/oven_recipe_sequencer_if.sv
// Panel-side bus of the recipe sequencer: slot programming, run control and status.
interface oven_recipe_sequencer_if #(
   parameter int unsigned STEPS = 4
);
   import oven_pkg::*;

   localparam int unsigned AW = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic              prog_we;
   logic [AW-1:0]     prog_addr;
   logic [TEMP_W-1:0] prog_temp;
   logic [TIME_W-1:0] prog_time;
   logic              go;
   logic              pause;
   logic              abort;
   logic [AW-1:0]     step_idx;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output prog_we, prog_addr, prog_temp, prog_time, go, pause, abort,
      input  step_idx, busy, done, err
   );

   modport slave (
      input  prog_we, prog_addr, prog_temp, prog_time, go, pause, abort,
      output step_idx, busy, done, err
   );

endinterface

// File: rtl/oven_tick_prescaler.sv
// Divides clk down to one-cycle tick pulses, CLK_DIV enabled cycles apart.
// Count freezes while en is low, so a paused interval resumes where it stopped.
module oven_tick_prescaler #(
   parameter int unsigned CLK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = en && (count == LAST);

   // Cycle counter: clear has priority, advances only when enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/oven_recipe_sequencer.sv
// Steps the oven through up to STEPS (temperature, duration) slots: preheat,
// timed cook, advance; supports pause/abort and flags unusable slots.
module oven_recipe_sequencer #(
   parameter int unsigned STEPS    = 4,
   parameter int unsigned CLK_DIV  = 1000,
   parameter int unsigned INTERVAL = oven_pkg::INTERVAL
) (
   input  logic                        clk,
   input  logic                        rst,
   oven_recipe_sequencer_if.slave      bus,
   input  logic [oven_pkg::TEMP_W-1:0] temp,
   output logic [oven_pkg::TEMP_W-1:0] set_temp,
   output logic [oven_pkg::TIME_W-1:0] set_timer,
   output logic [oven_pkg::TIME_W-1:0] timer,
   output logic                        oven_start,
   output logic                        oven_stop
);
   import oven_pkg::*;

   localparam int unsigned       AW         = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [TEMP_W-1:0] BAND       = TEMP_W'(INTERVAL);
   localparam logic [AW-1:0]     FIRST_SLOT = '0;
   localparam logic [AW-1:0]     LAST_SLOT  = AW'(STEPS - 1);

   recipe_t           ram [STEPS];
   seq_state_t        state;
   seq_state_t        resume;
   logic [AW-1:0]     step_idx;
   logic [AW-1:0]     idx_inc;
   logic              busy;
   logic              done;
   logic              err;
   logic              running;
   logic              prog_open;
   logic              tick;
   logic              tick_en;
   logic              tick_clr;
   logic [TIME_W-1:0] timer_inc;
   recipe_t           cur_slot;
   recipe_t           next_slot;

   assign bus.step_idx = step_idx;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err;

   assign running   = state inside {S_LOAD, S_PREHEAT, S_COOK, S_PAUSED, S_NEXT};
   assign prog_open = (state == S_IDLE) || (state == S_DONE);
   assign idx_inc   = step_idx + 1'b1;
   assign timer_inc = timer + 1'b1;
   assign cur_slot  = ram[step_idx];
   assign next_slot = ram[idx_inc];

   // Pause/abort gate the prescaler on the same edge, so a tick that coincides
   // with pause is withheld and fires again right after resume.
   assign tick_en  = (state == S_COOK) && !bus.pause && !bus.abort;
   assign tick_clr = (state == S_LOAD);

   oven_tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   // Recipe slots: written from the panel only while no program runs
   always_ff @(posedge clk) begin
      if (bus.prog_we && prog_open) begin
         ram[bus.prog_addr] <= '{temp: bus.prog_temp, dur: bus.prog_time};
      end
   end

   // Sequencer FSM with registered oven drives and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         resume     <= S_PREHEAT;
         step_idx   <= '0;
         set_temp   <= '0;
         set_timer  <= '0;
         timer      <= '0;
         oven_start <= 1'b0;
         oven_stop  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (running && bus.abort) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            oven_start <= 1'b0;
            oven_stop  <= 1'b1;
         end else if (bus.pause && (state == S_PREHEAT || state == S_COOK)) begin
            resume     <= state;
            state      <= S_PAUSED;
            oven_start <= 1'b0;
            oven_stop  <= 1'b1;
         end else begin
            unique case (state)
               S_IDLE, S_DONE: begin
                  if (bus.go && ram[FIRST_SLOT].dur != '0) begin
                     state    <= S_LOAD;
                     step_idx <= '0;
                     err      <= 1'b0;
                     busy     <= 1'b1;
                  end else if (bus.go) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_LOAD: begin
                  set_temp  <= cur_slot.temp;
                  set_timer <= cur_slot.dur;
                  timer     <= '0;
                  if (cur_slot.temp < BAND) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     state      <= S_PREHEAT;
                     oven_start <= 1'b1;
                     oven_stop  <= 1'b0;
                  end
               end
               S_PREHEAT: begin
                  if (temp >= set_temp - BAND) begin
                     state <= S_COOK;
                  end
               end
               S_COOK: begin
                  if (tick) begin
                     timer <= timer_inc;
                     if (timer_inc == set_timer) begin
                        state      <= S_NEXT;
                        oven_start <= 1'b0;
                        oven_stop  <= 1'b1;
                     end
                  end
               end
               S_PAUSED: begin
                  if (!bus.pause) begin
                     state      <= resume;
                     oven_start <= 1'b1;
                     oven_stop  <= 1'b0;
                  end
               end
               S_NEXT: begin
                  if (step_idx == LAST_SLOT || next_slot.dur == '0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     step_idx <= idx_inc;
                     state    <= S_LOAD;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oven_recipe_sequencer.sv
// Bench for oven_recipe_sequencer: phase/elapsed-time model checked every
// cycle, plus directed recipes with hand-computed cycle counts and values.
module tb_oven_recipe_sequencer;

   localparam int unsigned STEPS    = 4;
   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned INTERVAL = 10;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [7:0] temp = 8'd0;
   logic [7:0] set_temp;
   logic [3:0] set_timer;
   logic [3:0] timer;
   logic       oven_start;
   logic       oven_stop;

   int tests = 0;
   int fails = 0;

   oven_recipe_sequencer_if #(.STEPS(STEPS)) bus();

   oven_recipe_sequencer #(
      .STEPS    (STEPS),
      .CLK_DIV  (CLK_DIV),
      .INTERVAL (INTERVAL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .temp       (temp),
      .set_temp   (set_temp),
      .set_timer  (set_timer),
      .timer      (timer),
      .oven_start (oven_start),
      .oven_stop  (oven_stop)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_LOAD, M_HEAT, M_COOK, M_PAUSE, M_NEXT, M_DONE} mphase_t;

   mphase_t ph      = M_IDLE;
   mphase_t m_saved = M_HEAT;
   int      m_idx   = 0;
   int      m_st    = 0;
   int      m_stm   = 0;
   int      m_act   = 0;      // active cook cycles in the current step
   bit      m_done  = 1'b0;
   bit      m_err   = 1'b0;
   int      m_tmp [STEPS];
   int      m_dur [STEPS];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph = M_IDLE; m_idx = 0; m_st = 0; m_stm = 0; m_act = 0;
         m_done = 1'b0; m_err = 1'b0;
      end else begin
         m_done = 1'b0;
         if (ph == M_IDLE || ph == M_DONE) begin
            if (bus.go && m_dur[0] != 0) begin
               ph = M_LOAD; m_idx = 0; m_err = 1'b0;
            end else if (bus.go) begin
               ph = M_DONE;
            end else begin
               ph = M_IDLE;
            end
            if (bus.prog_we) begin
               m_tmp[bus.prog_addr] = int'(bus.prog_temp);
               m_dur[bus.prog_addr] = int'(bus.prog_time);
            end
         end else if (bus.abort) begin
            ph = M_DONE;
         end else if (bus.pause && (ph == M_HEAT || ph == M_COOK)) begin
            m_saved = ph;
            ph      = M_PAUSE;
         end else begin
            case (ph)
               M_LOAD: begin
                  m_st = m_tmp[m_idx]; m_stm = m_dur[m_idx]; m_act = 0;
                  if (m_st < INTERVAL) begin m_err = 1'b1; ph = M_DONE; end
                  else ph = M_HEAT;
               end
               M_HEAT: if (int'(temp) + INTERVAL >= m_st) ph = M_COOK;
               M_COOK: begin
                  m_act++;
                  if (m_act == m_stm * CLK_DIV) ph = M_NEXT;
               end
               M_PAUSE: if (!bus.pause) ph = m_saved;
               M_NEXT: begin
                  if (m_idx == STEPS - 1 || m_dur[m_idx + 1] == 0) begin
                     ph = M_DONE; m_done = 1'b1;
                  end else begin
                     m_idx++; ph = M_LOAD;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic e_run;
   logic e_busy;

   always @(negedge clk) begin
      e_run  = (ph == M_HEAT) || (ph == M_COOK);
      e_busy = (ph != M_IDLE) && (ph != M_DONE);
      tests++;
      if (set_temp !== 8'(m_st) || set_timer !== 4'(m_stm) ||
          timer !== 4'(m_act / CLK_DIV) || oven_start !== e_run ||
          oven_stop !== !e_run || bus.step_idx !== 2'(m_idx) ||
          bus.busy !== e_busy || bus.done !== m_done || bus.err !== m_err) begin
         fails++;
         $display("FAIL cycle t=%0t got st=%0d stm=%0d tmr=%0d start=%b stop=%b idx=%0d busy=%b done=%b err=%b required st=%0d stm=%0d tmr=%0d start=%b stop=%b idx=%0d busy=%b done=%b err=%b",
                  $time, set_temp, set_timer, timer, oven_start, oven_stop, bus.step_idx,
                  bus.busy, bus.done, bus.err, m_st, m_stm, m_act / CLK_DIV, e_run, !e_run,
                  m_idx, e_busy, m_done, m_err);
      end
   end

   // Set-temperature captured at each oven_start rising edge
   int   heat_q [$];
   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (oven_start && !prev_start) heat_q.push_back(int'(set_temp));
      prev_start = oven_start;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic prog(input int a, input int t, input int d);
      bus.prog_addr = 2'(a);
      bus.prog_temp = 8'(t);
      bus.prog_time = 4'(d);
      bus.prog_we   = 1'b1;
      @(negedge clk);
      bus.prog_we = 1'b0;
   endtask

   // Pulse go, apply timed events (cycle numbers are negedges after go; -1 = none),
   // stop when busy has dropped, then check cycle count and done pulses.
   task automatic run_prog(input string name, input int exp_n, input int exp_done,
                           input int pause_at, input int pause_len, input int abort_at,
                           input int rst_at, input int temp_at, input int temp_val,
                           input int we_at, input int chk_at, input int chk_timer);
      int n  = 0;
      int dn = 0;
      bus.go = 1'b1;
      while (1) begin
         @(negedge clk);
         n++;
         bus.go = 1'b0;
         if (bus.done) dn++;
         bus.pause   = (n >= pause_at) && (n < pause_at + pause_len);
         bus.abort   = (n == abort_at);
         bus.prog_we = (n == we_at);
         if (n == temp_at) temp = 8'(temp_val);
         if (n == chk_at) check({name, "_timer"}, int'(timer), chk_timer);
         if (n == rst_at) begin
            #2 rst = 1'b1;
            #1;
            check({name, "_async_stop"}, int'(oven_stop), 1);
            check({name, "_async_timer"}, int'(timer), 0);
         end
         if (n == rst_at + 1) rst = 1'b0;
         if (n >= 2 && !bus.busy && !rst) break;
         if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, bus.busy, n);
            break;
         end
      end
      bus.pause   = 1'b0;
      bus.abort   = 1'b0;
      bus.prog_we = 1'b0;
      check({name, "_cycles"}, n, exp_n);
      check({name, "_done_pulses"}, dn, exp_done);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int exp_heat [4];
      exp_heat = '{100, 150, 120, 80};
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_temp = '0; bus.prog_time = '0;
      bus.go = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;

      repeat (2) @(negedge clk);
      check("reset_stop", int'(oven_stop), 1);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_set_timer", int'(set_timer), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single 3-tick step, temp within band
      prog(0, 100, 3); prog(1, 60, 0); prog(2, 70, 1); prog(3, 80, 1);
      temp = 8'd95;
      run_prog("single", 16, 1, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("single_set_temp", int'(set_temp), 100);
      check("single_set_timer", int'(set_timer), 3);
      check("single_timer", int'(timer), 3);
      check("single_stop", int'(oven_stop), 1);

      // Four full slots, oven already hot
      prog(0, 100, 2); prog(1, 150, 2); prog(2, 120, 1); prog(3, 80, 1);
      temp = 8'd255;
      heat_q.delete();
      run_prog("four", 37, 1, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("four_heat_count", heat_q.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("four_heat_%0d", i), (i < heat_q.size()) ? heat_q[i] : -1, exp_heat[i]);
      check("four_last_idx", int'(bus.step_idx), 3);

      // Unusable temperature, then an empty program, then recovery
      prog(0, 5, 4);
      run_prog("low_temp", 2, 0, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("low_temp_err", int'(bus.err), 1);
      check("low_temp_stop", int'(oven_stop), 1);
      prog(0, 100, 0);
      run_prog("empty", 2, 0, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("empty_err_kept", int'(bus.err), 1);
      prog(0, 100, 1); prog(1, 100, 0);
      run_prog("recover", 8, 1, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("recover_err", int'(bus.err), 0);

      // Pause for 5*CLK_DIV cycles with timer at 1
      prog(0, 100, 3);
      run_prog("pause", 37, 1, 7, 20, -1, -1, -1, 0, -1, 26, 1);

      // Pause coinciding with the completing tick
      prog(0, 100, 1);
      run_prog("pause_edge", 12, 1, 6, 3, -1, -1, -1, 0, -1, 8, 0);

      // Abort while preheating
      prog(0, 100, 2);
      temp = 8'd50;
      run_prog("abort", 6, 0, -1, 0, 5, -1, -1, 0, -1, -1, 0);
      check("abort_stop", int'(oven_stop), 1);

      // Reset mid-cook, slots survive reset
      temp = 8'd255;
      prog(0, 100, 3);
      run_prog("reset", 9, 0, -1, 0, -1, 8, -1, 0, -1, 7, 1);
      run_prog("after_reset", 16, 1, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("after_reset_set_timer", int'(set_timer), 3);

      // Write attempt while busy is ignored
      prog(0, 100, 1);
      bus.prog_addr = 2'd0; bus.prog_temp = 8'd200; bus.prog_time = 4'd5;
      run_prog("we_busy", 8, 1, -1, 0, -1, -1, -1, 0, 3, -1, 0);
      run_prog("we_rerun", 8, 1, -1, 0, -1, -1, -1, 0, -1, -1, 0);
      check("we_rerun_set_temp", int'(set_temp), 100);
      check("we_rerun_set_timer", int'(set_timer), 1);

      // Preheat threshold: 89 holds, 90 releases
      temp = 8'd89;
      run_prog("threshold", 26, 1, -1, 0, -1, -1, 20, 90, -1, 19, 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/oven_recipe_sequencer.md
Name: oven_recipe_sequencer

Overview:
- Runs a multi-step cooking program on the oven FSM by driving its set_temp, set_timer, timer, start and stop inputs.
- Holds up to STEPS programmed steps. Each step is a (temperature, duration) pair.
- For each step it waits for preheat, counts prescaled time ticks, then advances to the next step.
- Sits between the user-panel register interface and the oven module.

Parameters:
- STEPS, 4, number of recipe slots (power of two; address width = log2(STEPS)).
- CLK_DIV, 1000, clk cycles per timer tick.
- INTERVAL, 10, temperature hysteresis band; must equal the oven's band.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- prog_we  in  1  write strobe for recipe slot
- prog_addr  in  log2(STEPS)  slot index
- prog_temp  in  8  slot target temperature
- prog_time  in  4  slot duration in ticks; 0 = end-of-program marker
- go  in  1  start program (level sampled on clk)
- pause  in  1  freeze timing while high
- abort  in  1  terminate program
- temp  in  8  measured oven temperature
- set_temp  out  8  to oven set_temp
- set_timer  out  4  to oven set_timer
- timer  out  4  to oven timer (elapsed ticks in current step)
- oven_start  out  1  to oven start
- oven_stop  out  1  to oven stop
- step_idx  out  log2(STEPS)  current slot
- busy  out  1  program running
- done  out  1  one-cycle pulse when program completes normally
- err  out  1  sticky; cleared by next accepted go or rst

Behaviour:
- Reset values:
  - All outputs 0, except oven_stop=1 and set_timer=0.
  - State IDLE; prescaler cleared.
  - Recipe RAM not cleared.
- Recipe writes:
  - prog_we is accepted only in IDLE/DONE and takes effect on the next clk edge.
  - prog_we is ignored while busy.
- States and transitions:
  - IDLE: oven_stop=1.
    - go=1 and slot0.time!=0 -> LOAD with step_idx=0, err cleared.
    - go=1 and slot0.time==0 -> DONE with no done pulse.
  - LOAD (1 cycle):
    - Latch set_temp/set_timer from slot[step_idx]; timer=0; prescaler=0.
    - If prog_temp<INTERVAL: err=1 -> DONE, no done pulse (the oven would refuse this step).
    - Otherwise -> PREHEAT.
  - PREHEAT:
    - oven_stop=0, oven_start=1, timer held at 0.
    - temp >= set_temp-INTERVAL -> COOK.
  - COOK:
    - oven_start=1. Prescaler counts 0..CLK_DIV-1; at wrap, timer increments by 1.
    - When timer reaches set_timer, on that same edge -> NEXT.
    - Timer never exceeds set_timer and never wraps.
  - PAUSED: entered from PREHEAT/COOK when pause=1.
    - oven_stop=1, oven_start=0; prescaler and timer frozen.
    - pause=0 -> return to the saved state; prescaler resumes from its frozen value.
  - NEXT (1 cycle):
    - Last slot, or next slot time==0 -> DONE with done pulse.
    - Otherwise step_idx+1 -> LOAD.
  - DONE: oven_stop=1, busy=0.
    - go=1 -> behaves as go in IDLE.
    - go=0 -> IDLE on the next cycle.
- busy=1 in LOAD, PREHEAT, COOK, PAUSED and NEXT.
- Priority each cycle: rst > abort > pause > normal transition.
  - abort in any busy state -> DONE next edge, oven_stop=1, no done pulse, err unchanged.
- go while busy is ignored.
- Simultaneous pause and the timer-complete edge: pause wins, timer frozen at set_timer-1+1 not applied. The wrap is lost until resume, and the tick repeats after resume.
- Outputs are registered. set_temp/set_timer are stable for the whole step.
- Timer compare is unsigned 4-bit. Temperature compare is unsigned 8-bit; set_temp-INTERVAL cannot underflow because of the LOAD check.
- rst mid-program: immediate return to reset values. The oven sees oven_stop=1 asynchronously.

Decomposition:
- Shared package oven_pkg:
  - INTERVAL constant.
  - Temperature width 8, time width 4.
  - Sequencer state encoding (IDLE, LOAD, PREHEAT, COOK, PAUSED, NEXT, DONE).
- One sub-module: oven_tick_prescaler.
  - Parameter CLK_DIV; inputs clk, rst, en, clr; output tick pulse.
  - Reused later by the panel display.

Test Plan:
- Slot0=(100,3), slot1 time 0; go=1; temp held 95 -> PREHEAT exits; set_temp=100, set_timer=3; timer steps 0,1,2,3 at CLK_DIV intervals; done pulse 1 cycle; oven_stop=1 after.
- Slots (100,2), (150,2), (120,1), (80,1); temp forced ≥ targets -> step_idx 0→1→2→3; set_temp sequence 100,150,120,80; done pulse after slot3; no wrap of step_idx.
- Slot0=(5,4); go -> err=1, busy never high beyond LOAD, no done, oven_stop=1; the next valid go clears err.
- COOK with timer=1; pause for 5*CLK_DIV cycles -> timer stays 1, oven_stop=1; release -> remaining ticks complete with total elapsed = set_timer ticks of active time.
- Abort during PREHEAT and rst during COOK -> oven_stop=1 next edge / immediately; no done; prog_we during busy leaves the slot unchanged (read back via rerun).
- temp=89 with set_temp=100 -> stays in PREHEAT with timer=0 indefinitely; temp=90 -> COOK next edge.
